// File: rtl/l2_arbiter.sv
// l2_arbiter: shares the single L2 port between the L1 I-cache and D-cache.
// Define L2_ARB_RR_EN for round-robin on contention; otherwise the D-side has fixed priority.
module l2_arbiter #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              icache_read,
    input  logic [ADDR_W-1:0] icache_address,
    output logic              icache_resp,
    output logic [LINE_W-1:0] icache_rdata,
    input  logic              dcache_read,
    input  logic              dcache_write,
    input  logic [ADDR_W-1:0] dcache_address,
    input  logic [LINE_W-1:0] dcache_wdata,
    output logic              dcache_resp,
    output logic [LINE_W-1:0] dcache_rdata,
    output logic              l2cmem_read,
    output logic              l2cmem_write,
    output logic [ADDR_W-1:0] l2cmem_address,
    output logic [LINE_W-1:0] l2cmem_wdata,
    input  logic              l2cmem_resp,
    input  logic [LINE_W-1:0] l2cmem_rdata
);
    typedef enum logic [1:0] {IDLE, SERVE, RESPOND} state_t;
    state_t state, state_n;
    logic owner_d, op_wr, i_req, d_req, grant_d, take;
    logic [ADDR_W-1:0] addr_q;
    logic [LINE_W-1:0] wdata_q, line_q;
    assign i_req = icache_read;
    assign d_req = dcache_read | dcache_write;
    assign take  = (state == IDLE) && (i_req || d_req);
`ifdef L2_ARB_RR_EN
    // last_d remembers whether the D-side won the previous grant
    logic last_d;
    always_ff @(posedge clk or posedge rst)
        if (rst) last_d <= 1'b0;
        else if (take) last_d <= grant_d;
    assign grant_d = d_req && (!i_req || !last_d);
`else
    assign grant_d = d_req;
`endif
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else state <= state_n;
    always_comb begin
        state_n = IDLE;
        state_n = state == IDLE  ? ((i_req || d_req) ? SERVE : IDLE) :
                  state == SERVE ? (l2cmem_resp ? RESPOND : SERVE) : IDLE;
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            owner_d <= 1'b0;
            op_wr   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            line_q  <= '0;
        end else begin
            if (take) begin
                owner_d <= grant_d;
                op_wr   <= grant_d && dcache_write;
                addr_q  <= grant_d ? dcache_address : icache_address;
                wdata_q <= grant_d ? dcache_wdata : '0;
            end
            if (state == SERVE && l2cmem_resp) line_q <= op_wr ? '0 : l2cmem_rdata;
        end
    assign l2cmem_read    = (state == SERVE) && !op_wr;
    assign l2cmem_write   = (state == SERVE) && op_wr;
    assign l2cmem_address = addr_q;
    assign l2cmem_wdata   = wdata_q;
    assign icache_resp    = (state == RESPOND) && !owner_d;
    assign dcache_resp    = (state == RESPOND) && owner_d;
    assign icache_rdata   = line_q;
    assign dcache_rdata   = line_q;
endmodule

// File: doc/l2_arbiter.md
# l2_arbiter

Two-requester arbiter sharing the single L2 cache port between the L1 instruction cache (read-only) and the L1 data cache (read/write). It sits between the two L1 miss paths and the L2 cache controller. It latches the winning request and presents a stable request to the L2. It holds that request until the L2 responds, then returns a registered response and line to the winner.

## Interface
- ADDR_W, 32, address width in bits.
- LINE_W, 256, cache line width in bits (32-byte lines).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset, asynchronous and active-high.
- icache_read  in  1  I-side line read request, held until icache_resp.
- icache_address  in  ADDR_W  I-side line address.
- icache_resp  out  1  one-cycle completion pulse to the I-side.
- icache_rdata  out  LINE_W  returned line; valid only while icache_resp is high.
- dcache_read, dcache_write  in  1 each  D-side requests, held until dcache_resp.
- dcache_address  in  ADDR_W  D-side line address.
- dcache_wdata  in  LINE_W  D-side writeback line.
- dcache_resp  out  1  one-cycle completion pulse to the D-side.
- dcache_rdata  out  LINE_W  returned line; valid only while dcache_resp is high.
- l2cmem_read, l2cmem_write  out  1 each  request to the L2 controller.
- l2cmem_address  out  ADDR_W  L2 address.
- l2cmem_wdata  out  LINE_W  L2 write line.
- l2cmem_resp  in  1  L2 completion pulse.
- l2cmem_rdata  in  LINE_W  L2 line, sampled when l2cmem_resp is high.

## Operation
- FSM states:
  - IDLE: no request driven to L2.
  - SERVE: L2 request driven from latched registers.
  - RESPOND: winner's resp pulsed.
- IDLE:
  - If any request is present, select a winner and latch owner, address, wdata and op.
  - The D-side op is write if dcache_write is high; write takes precedence if both dcache_read and dcache_write are high.
  - Go to SERVE. Stay in IDLE if there is no request.
- SERVE:
  - l2cmem_read/l2cmem_write follow the latched op; address and wdata come from the latches.
  - Requester inputs are ignored in this state.
  - On l2cmem_resp, capture l2cmem_rdata into the line register and go to RESPOND.
- RESPOND:
  - Assert the owner's resp for exactly one cycle.
  - Both rdata outputs show the line register; zero it on writes.
  - Go to IDLE. The owner drops its request after seeing resp, so it is not re-granted.
- Arbitration (with the macro, see Configuration): round-robin on contention.
  - The last_grant register records the previous owner; on a tie, the side that did not last win is granted.
  - last_grant updates on entry to SERVE.
- Loser: keeps its request asserted. It is granted in the IDLE cycle that follows RESPOND.
- Reset values:
  - state = IDLE; last_grant = I (so D wins the first tie).
  - All outputs are 0, including latches and the line register.
- Reset mid-transaction: return to IDLE immediately and drop the outstanding L2 transaction without any resp. The L2 controller is reset by the same system reset.

## Timing
- Request first sampled in IDLE at cycle N: the L2 request is asserted at N+1.
- L2 response at cycle M: the L1 resp is asserted at M+1. The next grant decision is made at M+2.
- Minimum occupancy per transaction is 3 cycles: IDLE, SERVE, RESPOND.
- All L2-facing and L1-facing outputs are registered or decoded from state. There is no combinational path from any input to any output.
- l2cmem_read/l2cmem_write deassert in the cycle after l2cmem_resp.

## Configuration
- L2_ARB_RR_EN defined: round-robin arbitration as described, and the last_grant register is present.
- L2_ARB_RR_EN undefined: fixed priority, where the D-side always wins contention. The last_grant register is removed. The I-side can be starved while the D-side issues back-to-back requests.

## Test plan
- Lone I read, addr 0x0000_1000; L2 responds 4 cycles after its request with a line of all 0xA5 -> l2cmem_read high from N+1, icache_resp a single pulse at M+1 with icache_rdata = 0xA5…A5, dcache_resp stays 0.
- D write to 0x0000_2020 with wdata = 0x1234…; L2 resp 2 cycles later -> l2cmem_write=1, l2cmem_address=0x2020, l2cmem_wdata matches, dcache_resp a single pulse, dcache_rdata = 0.
- I and D requests asserted in the same cycle from reset, each held until resp -> D served first, then I. With L2_ARB_RR_EN undefined, D is served first as well.
- D continuously re-requests while I stays asserted -> with the macro, grants alternate D, I, D, I; without it, I is never granted over 10 D transactions.
- rst asserted during SERVE -> next edge shows state IDLE, all outputs 0, no resp pulse. A fresh I request after rst deasserts completes normally.
- Change icache_address during SERVE -> l2cmem_address stays at the latched value until RESPOND.
